// File: rtl/fp_align_if.sv
// Handshake and data bundle between the FP alignment stage and its neighbours.
// slave = the alignment stage itself, master = whoever feeds and drains it.
interface fp_align_if;
   logic        inValid;
   logic        inReady;
   logic [31:0] A;
   logic [31:0] B;
   logic        outValid;
   logic        outReady;
   logic [7:0]  exponentOut;
   logic [23:0] mantissaLarge;
   logic [23:0] mantissaSmall;
   logic        signLarge;
   logic        signSmall;
   logic        guardBit;
   logic        roundBit;
   logic        stickyBit;
   logic        swapped;
   logic        isNaN;
   logic        isInf;

   modport slave (
      input  inValid, A, B, outReady,
      output inReady, outValid, exponentOut, mantissaLarge, mantissaSmall,
             signLarge, signSmall, guardBit, roundBit, stickyBit, swapped, isNaN, isInf
   );

   modport master (
      output inValid, A, B, outReady,
      input  inReady, outValid, exponentOut, mantissaLarge, mantissaSmall,
             signLarge, signSmall, guardBit, roundBit, stickyBit, swapped, isNaN, isInf
   );
endinterface

// File: rtl/fp_align.sv
// Single-precision FP adder pre-add alignment: unpack, order by magnitude, multi-cycle right shift with G/R/S.
// Define FPALIGN_SUBNORMAL_EN to keep subnormals; otherwise exp==0 operands flush to signed zero.
module fp_align #(
   parameter int SHIFT_STEP = 1
) (
   input  logic      clock,
   input  logic      reset,
   fp_align_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} stateType;

   stateType    state, nextState;

   logic [7:0]  expA, expB, effExpA, effExpB, effExpL, effExpS, diff;
   logic [23:0] mantA, mantB, mantL, mantS;
   logic        bLarger, anyMaxExp, nanIn, infIn;

   logic [7:0]  exponentR, nextExponent;
   logic [23:0] mantLR, nextMantL;
   logic [25:0] alignR, nextAlign;
   logic        stickyR, nextSticky;
   logic        signLR, nextSignL, signSR, nextSignS;
   logic        swappedR, nextSwapped, nanR, nextNan, infR, nextInf;
   logic [7:0]  remainR, nextRemain;

   logic [4:0]  shiftAmt;
   logic [25:0] lostMask;

   assign expA = bus.A[30:23];
   assign expB = bus.B[30:23];

`ifdef FPALIGN_SUBNORMAL_EN
   assign effExpA = (expA == 8'd0) ? 8'd1 : expA;
   assign effExpB = (expB == 8'd0) ? 8'd1 : expB;
   assign mantA   = {expA != 8'd0, bus.A[22:0]};
   assign mantB   = {expB != 8'd0, bus.B[22:0]};
`else
   assign effExpA = expA;
   assign effExpB = expB;
   assign mantA   = (expA == 8'd0) ? 24'd0 : {1'b1, bus.A[22:0]};
   assign mantB   = (expB == 8'd0) ? 24'd0 : {1'b1, bus.B[22:0]};
`endif

   // Ordering uses the raw magnitude fields so a tie always keeps A as the larger operand.
   assign bLarger   = bus.B[30:0] > bus.A[30:0];
   assign effExpL   = bLarger ? effExpB : effExpA;
   assign effExpS   = bLarger ? effExpA : effExpB;
   assign mantL     = bLarger ? mantB : mantA;
   assign mantS     = bLarger ? mantA : mantB;
   assign diff      = effExpL - effExpS;
   assign anyMaxExp = (expA == 8'hFF) || (expB == 8'hFF);
   assign nanIn     = ((expA == 8'hFF) && (bus.A[22:0] != 23'd0)) ||
                      ((expB == 8'hFF) && (bus.B[22:0] != 23'd0));
   assign infIn     = anyMaxExp && !nanIn;

   // alignR holds {mantissaSmall, guard, round}; bits falling off the bottom feed sticky.
   assign shiftAmt = (remainR < 8'(SHIFT_STEP)) ? remainR[4:0] : 5'(SHIFT_STEP);
   assign lostMask = (26'd1 << shiftAmt) - 26'd1;

   always_comb begin
      // NOTE: every next-value gets its hold default first, so no path leaves one unassigned (no latch).
      nextState    = state;
      nextExponent = exponentR;
      nextMantL    = mantLR;
      nextAlign    = alignR;
      nextSticky   = stickyR;
      nextSignL    = signLR;
      nextSignS    = signSR;
      nextSwapped  = swappedR;
      nextNan      = nanR;
      nextInf      = infR;
      nextRemain   = remainR;

      unique case (state)
         IDLE: begin
            if (bus.inValid) begin
               nextExponent = effExpL;
               nextMantL    = mantL;
               nextAlign    = {mantS, 2'b00};
               nextSticky   = 1'b0;
               nextSignL    = bLarger ? bus.B[31] : bus.A[31];
               nextSignS    = bLarger ? bus.A[31] : bus.B[31];
               nextSwapped  = bLarger;
               nextNan      = nanIn;
               nextInf      = infIn;
               nextRemain   = diff;
               if (anyMaxExp || (diff == 8'd0)) begin
                  nextState = DONE;
               end else if (diff >= 8'd26) begin
                  nextAlign  = '0;
                  nextSticky = |mantS;
                  nextRemain = 8'd0;
                  nextState  = DONE;
               end else begin
                  nextState = SHIFT;
               end
            end
         end
         SHIFT: begin
            nextAlign  = alignR >> shiftAmt;
            nextSticky = stickyR | (|(alignR & lostMask));
            nextRemain = remainR - 8'(shiftAmt);
            if (nextRemain == 8'd0) nextState = DONE;
         end
         DONE: begin
            if (bus.outReady) nextState = IDLE;
         end
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of order.
      if (reset) begin
         state     <= IDLE;
         exponentR <= '0;
         mantLR    <= '0;
         alignR    <= '0;
         stickyR   <= 1'b0;
         signLR    <= 1'b0;
         signSR    <= 1'b0;
         swappedR  <= 1'b0;
         nanR      <= 1'b0;
         infR      <= 1'b0;
         remainR   <= '0;
      end else begin
         state     <= nextState;
         exponentR <= nextExponent;
         mantLR    <= nextMantL;
         alignR    <= nextAlign;
         stickyR   <= nextSticky;
         signLR    <= nextSignL;
         signSR    <= nextSignS;
         swappedR  <= nextSwapped;
         nanR      <= nextNan;
         infR      <= nextInf;
         remainR   <= nextRemain;
      end
   end

   assign bus.inReady       = (state == IDLE) && !reset;
   assign bus.outValid      = (state == DONE);
   assign bus.exponentOut   = exponentR;
   assign bus.mantissaLarge = mantLR;
   assign bus.mantissaSmall = alignR[25:2];
   assign bus.guardBit      = alignR[1];
   assign bus.roundBit      = alignR[0];
   assign bus.stickyBit     = stickyR;
   assign bus.signLarge     = signLR;
   assign bus.signSmall     = signSR;
   assign bus.swapped       = swappedR;
   assign bus.isNaN         = nanR;
   assign bus.isInf         = infR;
endmodule

// File: tb/tb_fp_align.sv
// Scoreboard bench for fp_align: a driver pushes hand-computed expectations, a monitor pops them on outValid.
// Honours FPALIGN_SUBNORMAL_EN for the subnormal sticky expectation.
module tb_fp_align #(
   parameter int SHIFT_STEP = 1
);
   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [7:0]  expo;
      logic [23:0] manL;
      logic [23:0] manS;
      logic [7:0]  flags;   // {signL, signS, g, r, s, swapped, nan, inf}
      int          lat;
      int          acceptCycle;
   } vecT;

   logic clock = 1'b0;
   logic reset;
   int   checks = 0;
   int   failures = 0;
   int   cycleCount = 0;
   vecT  sbQ[$];

   fp_align_if bus();

   fp_align #(.SHIFT_STEP(SHIFT_STEP)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cycleCount <= cycleCount + 1;

   task automatic check(input string name, input logic [127:0] actual, input logic [127:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   function automatic logic [127:0] snap();
      return {63'd0, bus.exponentOut, bus.mantissaLarge, bus.mantissaSmall, bus.signLarge, bus.signSmall,
              bus.guardBit, bus.roundBit, bus.stickyBit, bus.swapped, bus.isNaN, bus.isInf, bus.outValid};
   endfunction

   function automatic int latFor(input int diff);
      return 1 + (diff + SHIFT_STEP - 1) / SHIFT_STEP;
   endfunction

   function automatic vecT mk(input logic [31:0] a, input logic [31:0] b, input logic [7:0] expo,
                              input logic [23:0] manL, input logic [23:0] manS, input logic [7:0] flags,
                              input int diff);
      vecT v;
      v.a = a; v.b = b; v.expo = expo; v.manL = manL; v.manS = manS; v.flags = flags;
      v.lat = latFor(diff);
      v.acceptCycle = 0;
      return v;
   endfunction

   task automatic runOp(input vecT v, input int holdCycles);
      int waitCnt;
      vecT e;
      logic [127:0] held;
      waitCnt = 0;
      while (!bus.inReady && waitCnt < 100) begin
         @(posedge clock); #1;
         waitCnt++;
      end
      if (!bus.inReady) check("inReadyTimeout", 0, 1);
      bus.A = v.a;
      bus.B = v.b;
      bus.inValid = 1'b1;
      @(posedge clock); #1;
      e = v;
      e.acceptCycle = cycleCount;
      sbQ.push_back(e);
      bus.inValid = 1'b0;
      bus.A = 32'hDEADBEEF;
      bus.B = 32'h12345678;
      waitCnt = 0;
      while (!bus.outValid && waitCnt < 100) begin
         @(posedge clock); #1;
         waitCnt++;
      end
      if (!bus.outValid) begin
         check("outValidTimeout", 0, 1);
      end else begin
         held = snap();
         for (int i = 0; i < holdCycles; i++) begin
            @(posedge clock); #1;
            check("holdStable", snap(), held);
            check("holdInReady", bus.inReady, 0);
         end
         bus.outReady = 1'b1;
         @(posedge clock); #1;
         bus.outReady = 1'b0;
         check("releaseOutValid", bus.outValid, 0);
         check("releaseInReady", bus.inReady, 1);
      end
   endtask

   // Monitor: compares each result once, on the first sample where outValid is seen high.
   initial begin
      bit  seen;
      vecT e;
      seen = 1'b0;
      forever begin
         @(negedge clock);
         if (bus.outValid && !seen) begin
            seen = 1'b1;
            if (sbQ.size() == 0) begin
               check("unexpectedResult", 1, 0);
            end else begin
               e = sbQ.pop_front();
               check("exponentOut", bus.exponentOut, e.expo);
               check("mantissaLarge", bus.mantissaLarge, e.manL);
               check("mantissaSmall", bus.mantissaSmall, e.manS);
               check("signs", {bus.signLarge, bus.signSmall}, e.flags[7:6]);
               check("grs", {bus.guardBit, bus.roundBit, bus.stickyBit}, e.flags[5:3]);
               check("swapped", bus.swapped, e.flags[2]);
               check("special", {bus.isNaN, bus.isInf}, e.flags[1:0]);
               check("latency", cycleCount - e.acceptCycle + 1, e.lat);
            end
         end else if (!bus.outValid) begin
            seen = 1'b0;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic subSticky;
`ifdef FPALIGN_SUBNORMAL_EN
      subSticky = 1'b1;
`else
      subSticky = 1'b0;
`endif
      reset        = 1'b1;
      bus.inValid  = 1'b0;
      bus.outReady = 1'b0;
      bus.A        = 32'd0;
      bus.B        = 32'd0;
      repeat (3) @(posedge clock);
      #1;
      check("resetOutputs", snap(), 0);
      check("resetInReady", bus.inReady, 0);
      reset = 1'b0;
      @(posedge clock); #1;
      check("idleInReady", bus.inReady, 1);
      check("idleOutValid", bus.outValid, 0);

      runOp(mk(32'h3F800000, 32'h3F800000, 8'h7F, 24'h800000, 24'h800000, 8'b0000_0000, 0), 0);
      runOp(mk(32'h3F800000, 32'h40400000, 8'h80, 24'hC00000, 24'h400000, 8'b0000_0100, 1), 0);
      runOp(mk(32'h3F800000, 32'h33800000, 8'h7F, 24'h800000, 24'h000000, 8'b0010_0000, 24), 0);
      runOp(mk(32'h3F800000, 32'h00000001, 8'h7F, 24'h800000, 24'h000000,
               {4'b0000, subSticky, 3'b000}, 0), 0);
      runOp(mk(32'h7F800000, 32'h3F800000, 8'hFF, 24'h800000, 24'h800000, 8'b0000_0001, 0), 0);
      runOp(mk(32'h7FC00000, 32'h3F800000, 8'hFF, 24'hC00000, 24'h800000, 8'b0000_0010, 0), 0);
      runOp(mk(32'h40800000, 32'hBF800001, 8'h81, 24'h800000, 24'h200000, 8'b0101_0000, 2), 0);
      runOp(mk(32'h4B000000, 32'h3F800003, 8'h96, 24'h800000, 24'h000001, 8'b0000_1000, 23), 0);
      runOp(mk(32'hBF800000, 32'h3F800000, 8'h7F, 24'h800000, 24'h800000, 8'b1000_0000, 0), 0);
      runOp(mk(32'h4F000000, 32'h3F800000, 8'h9E, 24'h800000, 24'h000000, 8'b0000_1000, 0), 0);
      runOp(mk(32'h3F800000, 32'h41200000, 8'h82, 24'hA00000, 24'h100000, 8'b0000_0100, 3), 3);

      // Abort a diff=20 shift with reset; no result may ever be presented for it.
      bus.A = 32'h49800000;
      bus.B = 32'h3F800000;
      bus.inValid = 1'b1;
      @(posedge clock); #1;
      bus.inValid = 1'b0;
      @(posedge clock); #1;
      check("busyInReady", bus.inReady, 0);
      reset = 1'b1;
      @(posedge clock); #1;
      check("abortOutputs", snap(), 0);
      check("abortInReady", bus.inReady, 0);
      reset = 1'b0;
      #1;
      check("afterAbortInReady", bus.inReady, 1);
      repeat (30) @(posedge clock);
      #1;
      check("noAbortedResult", bus.outValid, 0);

      runOp(mk(32'h3F800000, 32'h40400000, 8'h80, 24'hC00000, 24'h400000, 8'b0000_0100, 1), 0);

      repeat (3) @(posedge clock);
      #1;
      check("scoreboardEmpty", sbQ.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fp_align.md
# fp_align

Pre-add alignment stage of the single-precision FP adder, the front-end counterpart of the normalize/round stage. Unpacks two IEEE-754 operands, orders them by magnitude, and right-shifts the smaller mantissa by the exponent difference with a multi-cycle shifter, producing guard/round/sticky bits. Results feed the mantissa adder, then normalization. Valid/ready handshake on both sides.

## Interface
- SHIFT_STEP, 1, bits shifted per SHIFT cycle; legal values 1, 2, 4.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- inValid  in  1  operands A/B valid.
- inReady  out  1  block can accept; equals (state==IDLE) && !reset.
- A, B  in  32  IEEE-754 single-precision operands.
- outValid  out  1  aligned result valid; held until outReady.
- outReady  in  1  downstream accepts the result.
- exponentOut  out  8  effective exponent of the larger operand.
- mantissaLarge, mantissaSmall  out  24  mantissas with implicit bit; Small is aligned.
- signLarge, signSmall  out  1  signs of the ordered operands.
- guardBit, roundBit, stickyBit  out  1  first, second, OR-of-remaining bits shifted out.
- swapped  out  1  B was the larger operand.
- isNaN, isInf  out  1  special-operand flags.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: on inValid && inReady, register unpacked operands:
  - Implicit bit = (exp != 0).
  - Effective exponent = 1 for subnormals, otherwise the raw exponent.
- Ordering: B is larger iff {expB,manB} > {expA,manA}. On a tie, A is larger and swapped=0.
- diff = effExpL − effExpS, 8-bit unsigned, never negative.
- Next state from IDLE:
  - DONE if any exponent is 255, diff == 0, or diff ≥ 26.
  - SHIFT otherwise.
- Special operands:
  - isNaN = 1 if any operand has exp 255 and mantissa ≠ 0.
  - isInf = 1 if any operand has exp 255 and mantissa == 0, and isNaN = 0.
  - Mantissas pass through unshifted; G/R/S = 0.
- diff ≥ 26: mantissaSmall = 0, guard = round = 0, sticky = |manS.
- SHIFT: each cycle shifts {manS, g, r} right by min(SHIFT_STEP, remaining). Sticky ORs in every bit leaving r. remaining decrements; go to DONE when it reaches 0.
- DONE: outValid = 1 and outputs are stable. On outReady, go to IDLE; inReady asserts the next cycle, so there is no same-cycle re-accept.
- exponentOut = effExpL, unchanged by shifting.

## Timing
- Reset: state IDLE; every output = 0, including outValid, all flags, and all data. inReady = 0 while reset is high.
- Latency from the accept edge to outValid high:
  - 1 cycle for the DONE-direct cases.
  - Otherwise 1 + ceil(diff/SHIFT_STEP).
- Throughput: one operation in flight. Minimum initiation interval = latency + 1.
- outValid && !outReady: all outputs held bit-stable.
- Reset mid-SHIFT or mid-DONE: abort, outputs to 0, state IDLE. The partial result is never presented.
- inValid while busy is ignored; inputs are sampled only on the accept edge.

## Configuration
- FPALIGN_SUBNORMAL_EN defined: subnormals are handled as above (implicit 0, effective exponent 1).
- FPALIGN_SUBNORMAL_EN undefined: an operand with exp == 0 is flushed to signed zero. Its mantissa is treated as 0 and its effective exponent as 0, so the sticky contribution is 0.

## Test plan
- A=0x3F800000, B=0x3F800000: outValid 1 cycle after accept; exponentOut=0x7F, both mantissas 0x800000, G/R/S=0, swapped=0.
- A=0x3F800000, B=0x40400000, SHIFT_STEP=1: swapped=1, exponentOut=0x80, mantissaLarge=0xC00000, mantissaSmall=0x400000, latency 2.
- A=0x3F800000, B=0x33800000, SHIFT_STEP=1 and 4:
  - mantissaSmall=0, guard=1, round=0, sticky=0.
  - Latency 25 with SHIFT_STEP=1; latency 7 with SHIFT_STEP=4.
- A=0x3F800000, B=0x00000001:
  - Latency 1, mantissaSmall=0.
  - sticky=1 with FPALIGN_SUBNORMAL_EN; sticky=0 and mantissaSmall=0 without it.
- Special operands: A=0x7F800000, B=0x3F800000 → isInf=1, isNaN=0, latency 1. A=0x7FC00000 → isNaN=1.
- Backpressure and reset:
  - Hold outReady=0 for 3 cycles in DONE: outputs unchanged; inReady=0 throughout.
  - Assert reset during SHIFT (diff=20): next cycle all outputs 0 and inReady=1 after reset drops.
